// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the floating-point adder arbiter.
// Holds the controller state encoding, default sizing and an index-width helper.
package fp_arb_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    // Keeps index buses at least one bit wide when only one requester exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to the
// lowest asserted request below ptr. Purely combinational.
module rr_pick
    import fp_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic          hit_hi;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;

    // Scanning downward leaves the lowest qualifying index in each candidate.
    always_comb begin
        hit_hi = 1'b0;
        any    = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_lo = IW'(i);
                any    = 1'b1;
                if (i >= int'(ptr)) begin
                    idx_hi = IW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        idx = hit_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one multi-cycle floating-point adder among N requesters, round-robin.
// Operands are captured at issue so requesters may change inputs afterwards.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no operation; waits for any req while the adder reports ready
// ISSUE     | add_start strobe; winner and operands already registered
// WAIT_BUSY | waits for the adder to drop add_done (accepted the operation)
// WAIT_DONE | waits for add_done to return; result captured on that edge
// RESPOND   | ack pulses to the owner; pointer advances past the owner
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   result,
    output logic           busy,
    output logic           add_start,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic           add_done,
    input  logic [W-1:0]   add_result
);

    localparam int IW = idx_width(N);

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_gnt;
    logic          pick_any;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          take;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                sel_a = op_a[i*W +: W];
                sel_b = op_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (pick_any && add_done) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: if (!add_done) state_nx = WAIT_DONE;
            WAIT_DONE: if (add_done) state_nx = RESPOND;
            RESPOND:   state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Decoded from state and registered grant only, so req/add_done never
    // reach add_start or ack combinationally.
    always_comb begin
        add_start = (state == ISSUE);
        busy      = (state != IDLE);
        ack       = (state == RESPOND) ? grant : '0;
    end

    assign take = (state == IDLE) && pick_any && add_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            gidx   <= '0;
            grant  <= '0;
            add_a  <= '0;
            add_b  <= '0;
            result <= '0;
        end else begin
            if (take) begin
                grant <= pick_gnt;
                gidx  <= pick_idx;
                add_a <= sel_a;
                add_b <= sel_b;
            end
            if (state == WAIT_DONE && add_done) begin
                result <= add_result;
            end
            if (state == RESPOND) begin
                grant <= '0;
                ptr   <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a lookup-table adder stand-in whose
// sums are hand-computed IEEE-754 single values.
module tb_fp_add_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           busy;
    logic           add_start;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_done;
    logic [W-1:0]   add_result;

    logic stub_done;
    logic hold_low;
    int   stub_lat;
    int   checks;
    int   errors;

    fp_add_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .grant      (grant),
        .ack        (ack),
        .result     (result),
        .busy       (busy),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_done   (add_done),
        .add_result (add_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign add_done = stub_done & ~hold_low;

    function automatic logic [W-1:0] fadd_lut(input logic [W-1:0] a, input logic [W-1:0] b);
        case ({a, b})
            {32'h3FC0_0000, 32'h4010_0000}: return 32'h4070_0000; // 1.5 + 2.25
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000; // 1 + 1
            {32'h4000_0000, 32'h4040_0000}: return 32'h40A0_0000; // 2 + 3
            {32'h3F00_0000, 32'h3E80_0000}: return 32'h3F40_0000; // 0.5 + 0.25
            {32'hC000_0000, 32'h3F80_0000}: return 32'hBF80_0000; // -2 + 1
            {32'h4120_0000, 32'h40A0_0000}: return 32'h4170_0000; // 10 + 5
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Adder stand-in: drops ready after a start, returns the sum stub_lat cycles later.
    initial begin
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        stub_done  = 1'b1;
        add_result = '0;
        forever begin
            @(negedge clk);
            if (add_start === 1'b1) begin
                sa        = add_a;
                sb        = add_b;
                stub_done = 1'b0;
                repeat (stub_lat) @(negedge clk);
                add_result = fadd_lut(sa, sb);
                stub_done  = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill_garbage();
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = 32'hA5A5_0000 + 32'(i);
            op_b[i*W +: W] = 32'h5A5A_0000 + 32'(i);
        end
    endtask

    task automatic load(input int slot, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[slot*W +: W] = a;
        op_b[slot*W +: W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] a, output logic [W-1:0] r,
                            output int starts, output int cyc_to_start);
        a = '0;
        r = '0;
        starts = 0;
        cyc_to_start = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (add_start) begin
                starts++;
                if (cyc_to_start < 0) cyc_to_start = c;
            end
            if (ack != '0) begin
                a = ack;
                r = result;
                return;
            end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (add_start) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [N-1:0] exp_ack;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    logic [W-1:0] slot_a[N];
    logic [W-1:0] slot_b[N];
    logic [W-1:0] slot_r[N];

    initial begin
        logic [N-1:0] a;
        logic [W-1:0] r;
        int           st;
        int           cs;
        bit           ok;
        bit           clean;
        int           nack;
        logic [N-1:0] exp_seq[4];

        checks   = 0;
        errors   = 0;
        stub_lat = 2;
        hold_low = 1'b0;
        rst      = 1'b1;
        req      = '0;
        op_a     = '0;
        op_b     = '0;

        vecs[0] = '{4'b0010, 32'h3FC0_0000, 32'h4010_0000, 2, 4'b0010, 32'h4070_0000};
        vecs[1] = '{4'b0001, 32'h3F80_0000, 32'h3F80_0000, 3, 4'b0001, 32'h4000_0000};
        vecs[2] = '{4'b1000, 32'h4000_0000, 32'h4040_0000, 5, 4'b1000, 32'h40A0_0000};
        vecs[3] = '{4'b0100, 32'h3F00_0000, 32'h3E80_0000, 2, 4'b0100, 32'h3F40_0000};
        vecs[4] = '{4'b0100, 32'hC000_0000, 32'h3F80_0000, 4, 4'b0100, 32'hBF80_0000};

        slot_a[0] = 32'h3F80_0000; slot_b[0] = 32'h3F80_0000; slot_r[0] = 32'h4000_0000;
        slot_a[1] = 32'h3FC0_0000; slot_b[1] = 32'h4010_0000; slot_r[1] = 32'h4070_0000;
        slot_a[2] = 32'h4000_0000; slot_b[2] = 32'h4040_0000; slot_r[2] = 32'h40A0_0000;
        slot_a[3] = 32'h3F00_0000; slot_b[3] = 32'h3E80_0000; slot_r[3] = 32'h3F40_0000;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_add_start", 32'(add_start), 32'h0);
        check("rst_add_a", add_a, 32'h0);
        check("rst_add_b", add_b, 32'h0);
        rst = 1'b0;

        // Single-requester vectors
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            fill_garbage();
            for (int s = 0; s < N; s++) begin
                if (vecs[v].req[s]) load(s, vecs[v].a, vecs[v].b);
            end
            stub_lat = vecs[v].lat;
            req = vecs[v].req;
            wait_ack(40, a, r, st, cs);
            check($sformatf("vec%0d_ack", v), 32'(a), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d_result", v), r, vecs[v].exp_res);
            check($sformatf("vec%0d_starts", v), 32'(st), 32'd1);
            check($sformatf("vec%0d_start_latency", v), 32'(cs), 32'd1);
            req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_ack_one_cycle", v), 32'(ack), 32'h0);
            check($sformatf("vec%0d_idle_after", v), 32'({busy, grant}), 32'h0);
        end

        // All four together from reset: served 0,1,2,3
        do_reset();
        fill_garbage();
        for (int s = 0; s < N; s++) load(s, slot_a[s], slot_b[s]);
        stub_lat = 3;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, a, r, st, cs);
            check($sformatf("all4_ack%0d", k), 32'(a), 32'(1 << k));
            check($sformatf("all4_result%0d", k), r, slot_r[k]);
            check($sformatf("all4_starts%0d", k), 32'(st), 32'd1);
            req = req & ~a;
        end
        req = '0;

        // req[0] and req[2] held: must alternate
        do_reset();
        fill_garbage();
        load(0, slot_a[0], slot_b[0]);
        load(2, slot_a[2], slot_b[2]);
        stub_lat = 2;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0100;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, a, r, st, cs);
            check($sformatf("alt_ack%0d", k), 32'(a), 32'(exp_seq[k]));
            check($sformatf("alt_result%0d", k), r, (exp_seq[k] == 4'b0001) ? slot_r[0] : slot_r[2]);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // req[1] dropped during WAIT_BUSY, operands scrambled after capture
        fill_garbage();
        load(1, slot_a[1], slot_b[1]);
        stub_lat = 4;
        req = 4'b0010;
        wait_start(20, ok);
        check("drop_saw_start", 32'(ok), 32'd1);
        @(negedge clk);
        req = '0;
        load(1, 32'h1234_5678, 32'h8765_4321);
        wait_ack(30, a, r, st, cs);
        check("drop_ack", 32'(a), 32'b0010);
        check("drop_result", r, 32'h4070_0000);
        check("drop_operand_hold", add_a, 32'h3FC0_0000);
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack != '0) nack++;
        end
        check("drop_no_extra_ack", 32'(nack), 32'd0);

        // Reset in WAIT_DONE; ptr was 2 before the abort
        fill_garbage();
        load(2, slot_a[2], slot_b[2]);
        stub_lat = 8;
        req = 4'b0100;
        wait_start(20, ok);
        check("abort_saw_start", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs_zero",
              32'({grant, ack, busy, add_start}), 32'h0);
        check("abort_add_a", add_a, 32'h0);
        check("abort_add_b", add_b, 32'h0);
        check("abort_result", result, 32'h0);
        clean = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack != '0 || busy) clean = 1'b0;
        end
        check("abort_late_done_ignored", 32'(clean), 32'd1);
        fill_garbage();
        load(1, slot_a[0], slot_b[0]);
        load(3, 32'h4120_0000, 32'h40A0_0000);
        stub_lat = 3;
        req = 4'b1010;
        wait_ack(40, a, r, st, cs);
        check("abort_ptr_zero_ack", 32'(a), 32'b0010);
        check("abort_ptr_zero_result", r, 32'h4000_0000);
        req = 4'b1000;
        wait_ack(40, a, r, st, cs);
        check("abort_req3_ack", 32'(a), 32'b1000);
        check("abort_req3_result", r, 32'h4170_0000);
        req = '0;

        // Adder not ready after reset blocks issue
        hold_low = 1'b1;
        do_reset();
        fill_garbage();
        load(2, slot_a[3], slot_b[3]);
        stub_lat = 2;
        req = 4'b0100;
        clean = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (add_start || grant != '0 || busy) clean = 1'b0;
        end
        check("notready_blocked", 32'(clean), 32'd1);
        hold_low = 1'b0;
        wait_ack(40, a, r, st, cs);
        check("notready_start_latency", 32'(cs), 32'd1);
        check("notready_ack", 32'(a), 32'b0100);
        check("notready_result", r, 32'h3F40_0000);
        req = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
